// File: rtl/audio_pkg.sv
// Shared audio definitions: capture FSM states, ADC sample slice and the 6-bit magnitude helper.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RECORD = 2'd2,
        DONE   = 2'd3
    } cap_state_t;

    localparam int SAMPLE_MSB = 31;
    localparam int SAMPLE_LSB = 26;
    localparam int SAMPLE_W   = 6;

    // -32 maps to 6'd32, which still fits because the result is unsigned.
    function automatic logic [SAMPLE_W-1:0] magnitude(input logic [SAMPLE_W-1:0] s);
        return s[SAMPLE_W-1] ? (~s + 6'd1) : s;
    endfunction

endpackage

// File: rtl/mic_sample_fmt.sv
// Slices the 6-bit signed sample out of an ADC word and derives its magnitude.
// With MIC_TRIGGER_EN it also flags samples at or above THRESH.
module mic_sample_fmt
    import audio_pkg::*;
#(
    parameter logic [SAMPLE_W-1:0] THRESH = 6'd8
) (
    input  logic [31:0]         sample,
    output logic [SAMPLE_W-1:0] s,
    output logic [SAMPLE_W-1:0] mag
`ifdef MIC_TRIGGER_EN
    ,
    output logic                loud
`endif
);

    logic unused_low;

    assign s          = sample[SAMPLE_MSB:SAMPLE_LSB];
    assign mag        = magnitude(s);
    assign unused_low = ^sample[SAMPLE_LSB-1:0];

`ifdef MIC_TRIGGER_EN
    assign loud = (mag >= THRESH);
`else
    logic unused_thresh;
    assign unused_thresh = ^THRESH;
`endif

endmodule

// File: rtl/mic_capture.sv
// Microphone capture: drains the ADC FIFO and stores every DECIM-th sample as 6-bit data in RAM.
// Define MIC_TRIGGER_EN to add an ARMED state that waits for a sample with magnitude >= THRESH.
//
// state  | meaning
// IDLE   | waiting for start, FIFO still drained
// ARMED  | waiting for a loud sample (MIC_TRIGGER_EN only)
// RECORD | storing one of every DECIM consumed samples
// DONE   | recording finished, count/peak held
module mic_capture
    import audio_pkg::*;
#(
    parameter int                  ADDR_W = 14,
    parameter int                  LEN    = 16384,
    parameter int                  DECIM  = 4,
    parameter logic [SAMPLE_W-1:0] THRESH = 6'd8
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                audio_in_available,
    input  logic [31:0]         left_channel_audio_in,
    output logic                read_audio_in,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [SAMPLE_W-1:0] wr_data,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     count,
    output logic [SAMPLE_W-1:0] peak
);

    localparam int             DW       = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DW-1:0]  DECIM_M1 = DW'(DECIM - 1);
    localparam logic [ADDR_W:0] LEN_M1  = (ADDR_W + 1)'(LEN - 1);

    cap_state_t          state;
    logic [DW-1:0]       dcnt;
    logic [DW-1:0]       dcnt_nxt;
    logic [SAMPLE_W-1:0] s;
    logic [SAMPLE_W-1:0] mag;
    logic                consumed;
    logic                store;
    logic                last_store;

    mic_sample_fmt #(.THRESH(THRESH)) u_fmt (
        .sample (left_channel_audio_in),
        .s      (s),
        .mag    (mag)
`ifdef MIC_TRIGGER_EN
        ,
        .loud   (loud)
`endif
    );

`ifdef MIC_TRIGGER_EN
    logic loud;
    assign store = consumed && (((state == RECORD) && (dcnt == '0)) || ((state == ARMED) && loud));
`else
    assign store = consumed && (state == RECORD) && (dcnt == '0);
`endif

    assign read_audio_in = audio_in_available & ~reset;
    assign consumed      = read_audio_in;
    assign dcnt_nxt      = (dcnt == DECIM_M1) ? '0 : dcnt + 1'b1;
    assign last_store    = store && (count == LEN_M1);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= IDLE;
            dcnt    <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            count   <= '0;
            peak    <= '0;
        end else begin
            wr_en <= 1'b0;

            // A store on the same edge as stop still lands in RAM.
            if (store) begin
                wr_en   <= 1'b1;
                wr_addr <= count[ADDR_W-1:0];
                wr_data <= s;
                count   <= count + 1'b1;
                if (mag > peak)
                    peak <= mag;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        count   <= '0;
                        peak    <= '0;
                        dcnt    <= '0;
                        wr_addr <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
`ifdef MIC_TRIGGER_EN
                        state   <= ARMED;
`else
                        state   <= RECORD;
`endif
                    end
                end

                ARMED: begin
`ifdef MIC_TRIGGER_EN
                    if (stop || last_store) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (store) begin
                        state <= RECORD;
                        dcnt  <= dcnt_nxt;
                    end
`else
                    state <= IDLE;
                    busy  <= 1'b0;
`endif
                end

                RECORD: begin
                    if (consumed)
                        dcnt <= dcnt_nxt;
                    if (stop || last_store) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mic_capture.sv
// Directed plus randomized bench for mic_capture against a sample-index reference model.
module tb_mic_capture;

    localparam int ADDR_W = 14;
    localparam int LEN    = 8;
    localparam int DECIM  = 4;
    localparam int THRESH = 8;

    logic              CLOCK_50 = 1'b0;
    logic              reset;
    logic              start;
    logic              stop;
    logic              audio_in_available;
    logic [31:0]       left_channel_audio_in;
    logic              read_audio_in;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [5:0]        wr_data;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   count;
    logic [5:0]        peak;

    mic_capture #(
        .ADDR_W (ADDR_W),
        .LEN    (LEN),
        .DECIM  (DECIM),
        .THRESH (6'(THRESH))
    ) dut (
        .CLOCK_50              (CLOCK_50),
        .reset                 (reset),
        .start                 (start),
        .stop                  (stop),
        .audio_in_available    (audio_in_available),
        .left_channel_audio_in (left_channel_audio_in),
        .read_audio_in         (read_audio_in),
        .wr_en                 (wr_en),
        .wr_addr               (wr_addr),
        .wr_data               (wr_data),
        .busy                  (busy),
        .done                  (done),
        .count                 (count),
        .peak                  (peak)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad   = 0;

    // Reference model: one flag per phase, the consumed-sample index within the recording,
    // the number of stores so far and the running peak magnitude.
    bit m_arm, m_rec, m_done;
    int m_idx, m_cnt, m_peak;
    bit e_we;
    int e_addr, e_data;

    int obs_data[$];
    int obs_addr[$];

    function automatic int mag6(input bit [5:0] v);
        return v[5] ? 64 - int'(v) : int'(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_store(input bit [5:0] top);
        e_we   = 1'b1;
        e_addr = m_cnt;
        e_data = int'(top);
        m_cnt++;
        if (mag6(top) > m_peak) m_peak = mag6(top);
    endtask

    task automatic step(input bit av, input bit [5:0] top, input bit st, input bit sp);
        bit fin;
        audio_in_available    = av;
        left_channel_audio_in = {top, 26'($urandom)};
        start                 = st;
        stop                  = sp;
        #1;
        chk("read_audio_in", read_audio_in, 32'(av & ~reset));
        @(posedge CLOCK_50);
        e_we = 1'b0;
        fin  = 1'b0;
        if (reset) begin
            m_arm = 0; m_rec = 0; m_done = 0; m_idx = 0; m_cnt = 0; m_peak = 0;
        end else if (m_rec) begin
            if (av) begin
                if (m_idx % DECIM == 0) begin
                    model_store(top);
                    if (m_cnt == LEN) fin = 1'b1;
                end
                m_idx++;
            end
            if (sp || fin) begin m_rec = 0; m_done = 1; end
        end else if (m_arm) begin
            if (av && mag6(top) >= THRESH) begin
                model_store(top);
                m_idx = 1;
                m_arm = 0;
                m_rec = 1;
                if (m_cnt == LEN) fin = 1'b1;
            end
            if (sp || fin) begin m_arm = 0; m_rec = 0; m_done = 1; end
        end else if (st) begin
            m_idx = 0; m_cnt = 0; m_peak = 0; m_done = 0;
`ifdef MIC_TRIGGER_EN
            m_arm = 1;
`else
            m_rec = 1;
`endif
        end
        #1;
        chk("wr_en", wr_en, 32'(e_we));
        if (e_we) begin
            chk("wr_addr", 32'(wr_addr), 32'(e_addr));
            chk("wr_data", 32'(wr_data), 32'(e_data));
        end
        chk("count", 32'(count), 32'(m_cnt));
        chk("peak", 32'(peak), 32'(m_peak));
        chk("busy", busy, 32'(m_arm | m_rec));
        chk("done", done, 32'(m_done));
        if (wr_en === 1'b1) begin
            obs_data.push_back(int'(wr_data));
            obs_addr.push_back(int'(wr_addr));
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 0; stop = 0; audio_in_available = 0; left_channel_audio_in = 0;
        step(1, 6'd5, 0, 0);
        step(0, 6'd0, 1, 1);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        reset = 1'b0;
        step(0, 6'd0, 0, 1);

        // Ramp 0..31 back to back: one store every DECIM samples, LEN stores then DONE.
        obs_data.delete(); obs_addr.delete();
        step(0, 6'd0, 1, 0);
        for (int i = 0; i < 32; i++) step(1, 6'(i), 0, 0);
`ifndef MIC_TRIGGER_EN
        chk("ramp_nstores", 32'(obs_data.size()), 8);
        for (int k = 0; k < obs_data.size(); k++) begin
            chk("ramp_data", 32'(obs_data[k]), 32'(4 * k));
            chk("ramp_addr", 32'(obs_addr[k]), 32'(k));
        end
        chk("ramp_done", done, 1);
        chk("ramp_count", 32'(count), 8);
        chk("ramp_peak", 32'(peak), 28);
`else
        // Trigger: quiet samples are skipped while ARMED, first loud one is stored at addr 0.
        obs_data.delete(); obs_addr.delete();
        step(0, 6'd0, 1, 0);
        step(1, 6'd2, 0, 0);
        step(1, 6'd5, 0, 0);
        step(1, 6'd7, 0, 0);
        chk("armed_busy", busy, 1);
        step(1, 6'd9, 0, 0);
        step(1, 6'd1, 0, 0);
        chk("trig_nstores", 32'(obs_data.size()), 1);
        if (obs_data.size() > 0) begin
            chk("trig_first_data", 32'(obs_data[0]), 9);
            chk("trig_first_addr", 32'(obs_addr[0]), 0);
        end
        step(0, 6'd0, 0, 1);
`endif

        // Stop after three stores, then no further writes.
        obs_data.delete(); obs_addr.delete();
        step(0, 6'd0, 1, 0);
        n = 0;
        while (obs_data.size() < 3 && n < 200) begin
            step(1'($urandom), 6'($urandom_range(8, 24)), 0, 0);
            n++;
        end
        chk("stop_reached3", 32'(obs_data.size()), 3);
        step(0, 6'd0, 0, 1);
        for (int i = 0; i < 6; i++) step(1, 6'($urandom_range(8, 24)), 0, 0);
        chk("stop_nstores", 32'(obs_data.size()), 3);
        chk("stop_count", 32'(count), 3);
        chk("stop_done", done, 1);

        // Negative full scale.
        step(0, 6'd0, 1, 0);
        step(1, 6'h20, 0, 0);
        chk("negfs_wr_en", wr_en, 1);
        chk("negfs_data", 32'(wr_data), 32'h20);
        chk("negfs_peak", 32'(peak), 32);
        step(0, 6'd0, 0, 1);

        // Start from DONE clears count and peak, restarts at addr 0; start+stop in RECORD stops.
        step(0, 6'd0, 1, 0);
        chk("restart_count", 32'(count), 0);
        chk("restart_peak", 32'(peak), 0);
        step(1, 6'd12, 0, 0);
        chk("restart_addr", 32'(wr_addr), 0);
        step(0, 6'd0, 1, 1);
        chk("startstop_done", done, 1);
        chk("startstop_busy", busy, 0);

        // Reset mid-recording.
        step(0, 6'd0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 6'($urandom_range(8, 31)), 0, 0);
        reset = 1'b1;
        step(1, 6'd20, 0, 0);
        chk("midrst_wr_addr", 32'(wr_addr), 0);
        chk("midrst_wr_data", 32'(wr_data), 0);
        step(1, 6'd20, 1, 0);
        reset = 1'b0;
        step(1, 6'd20, 0, 1);
        chk("postrst_idle", busy, 0);

        // Random recordings with random availability, data and early stop.
        for (int r = 0; r < 4; r++) begin
            step(0, 6'd0, 1, 0);
            for (int i = 0; i < 50; i++)
                step(1'($urandom), 6'($urandom), 1'($urandom_range(0, 9) == 0),
                     $urandom_range(0, 39) == 0);
            step(0, 6'd0, 0, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mic_capture.md
# mic_capture

Captures microphone samples from the Audio_Controller ADC path and writes them, decimated and truncated to 6-bit signed format, into an external on-chip RAM, where they can be replayed like stored sounds. It is the capture-side counterpart of the ROM playback path. It sits between the Audio_Controller outputs `audio_in_available` / `left_channel_audio_in` and a single-port RAM write port. It also reports the captured length and peak magnitude to game logic.

## Interface
- `ADDR_W`, default 14: RAM address width.
- `LEN`, default 16384: samples per recording; must satisfy 1 ≤ `LEN` ≤ 2^`ADDR_W`.
- `DECIM`, default 4: store one of every `DECIM` consumed samples; must satisfy `DECIM` ≥ 1.
- `THRESH`, default 6'd8: trigger magnitude, used only with `MIC_TRIGGER_EN`.

Ports:
- `CLOCK_50`, in, 1: system clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high; driven from `~KEY[0]`.
- `start`, in, 1: one-cycle request to begin a recording.
- `stop`, in, 1: one-cycle request to end a recording early.
- `audio_in_available`, in, 1: ADC FIFO is non-empty.
- `left_channel_audio_in`, in, 32: ADC sample, valid while `audio_in_available` is high.
- `read_audio_in`, out, 1: pops the ADC FIFO.
- `wr_en`, out, 1: RAM write strobe.
- `wr_addr`, out, `ADDR_W`: RAM write address.
- `wr_data`, out, 6: RAM write data.
- `busy`, out, 1: high in ARMED or RECORD.
- `done`, out, 1: high in DONE.
- `count`, out, `ADDR_W+1`: number of samples written in the current or last recording.
- `peak`, out, 6: maximum stored magnitude, unsigned.

## Operation
- `read_audio_in` = `audio_in_available & ~reset` (combinational). The FIFO is drained in every state so it never overflows.
- A sample is "consumed" on each edge where `read_audio_in` is high.
- Sample conversion: `s = left_channel_audio_in[31:26]` (6-bit signed). Magnitude is `|s|`, 0..32, held in 6 bits unsigned.

States are IDLE, ARMED, RECORD and DONE.
- **IDLE:**
  - `start` → RECORD, or → ARMED when `MIC_TRIGGER_EN` is defined.
  - Entry into ARMED/RECORD clears `count`, `peak`, the decimation counter and the address.
- **ARMED:** a consumed sample with magnitude ≥ `THRESH` → RECORD. That triggering sample is the first one stored.
- **RECORD:**
  - Decimation counter `dcnt` counts 0..`DECIM`-1 and increments on each consumed sample, wrapping at `DECIM`-1.
  - A sample is stored when `dcnt`==0.
  - Each store increments `count` and `wr_addr`, and sets `peak` = max(`peak`, magnitude).
  - When the `LEN`-th store occurs → DONE.
- **stop** in ARMED or RECORD → DONE. `count` keeps the number written so far; a store issued on the same edge still completes.
- **DONE:**
  - `done`=1; `count` and `peak` are held.
  - `start` → ARMED/RECORD, as from IDLE, with counters cleared.
- `start` in ARMED or RECORD is ignored. `stop` in IDLE or DONE is ignored.
- `start` and `stop` on the same cycle in IDLE/DONE: `start` wins. In ARMED/RECORD: `stop` wins.

## Timing
- Reset values: state=IDLE; `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `count`=0, `peak`=0. `read_audio_in` is forced to 0 while `reset`=1.
- Store latency: a sample consumed on edge N produces `wr_en`=1 with `wr_addr`/`wr_data` during cycle N+1. `wr_en` is a single-cycle pulse.
- `wr_addr` for the k-th store (k from 0) is k. `count` updates in the same cycle as `wr_en`.
- State output timing:
  - `busy` rises the cycle after `start`.
  - `done` rises the cycle after the final `wr_en` edge, or the cycle after `stop`.
- Back-to-back availability (sample every cycle) is supported, with one store every `DECIM` cycles. With `DECIM`=1, `wr_en` may be high on consecutive cycles.
- Reset mid-recording aborts immediately. No further `wr_en` is issued, and RAM contents are left as-is.

## Configuration
- `MIC_TRIGGER_EN` defined: the ARMED state and the `THRESH` comparator exist. Recording waits for a loud sample, and `busy`=1 while ARMED.
- `MIC_TRIGGER_EN` undefined: there is no ARMED state. `start` goes straight to RECORD and the next consumed sample is stored. `THRESH` is unused.

## Structure
- The shared package `audio_pkg` holds:
  - the state enum (IDLE/ARMED/RECORD/DONE);
  - the sample-slice constants (bit positions 31:26, width 6);
  - the 6-bit `magnitude()` function, shared with the playback and detect logic.
- One natural sub-module is `mic_sample_fmt`, which does slice, magnitude and threshold compare. It is purely combinational.
- Everything else stays in `mic_capture`.

## Test plan
- Reset, then `start` with no trigger and `DECIM`=4, `LEN`=8, feeding 32 samples with top bits 0..31:
  - 8 `wr_en` pulses, addr 0..7, data 0,4,8,…,28;
  - `done`=1 with `count`=8;
  - `peak`=28.
- `MIC_TRIGGER_EN`, `THRESH`=8: samples 2,5,7,9,1,… → first store is 9 at addr 0; `busy`=1 throughout ARMED.
- `stop` after 3 stores → DONE, `count`=3, and no `wr_en` after the `stop` edge.
- Negative full scale: sample `6'b100000` stored → `wr_data`=6'h20, `peak`=32.
- Reset asserted mid-RECORD → all outputs zero on the next cycle, `read_audio_in`=0 while reset is high, and IDLE after reset is released.
- `start` in DONE → `count` and `peak` clear, a new recording starts at addr 0, and `start`+`stop` on the same cycle in RECORD → DONE.
